wbx_arbiter2: RTL and testbench

//  Round-robin arbiter sharing the single Wishbone B4 pipelined master port of the

---
 rtl/wbx_arbiter2.sv | 233 +++++++++++++++++++++++
 tb/tb_wbx_arbiter2.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbx_arbiter2.sv
// wbx_arbiter2: round-robin arbiter that lets two Wishbone B4 pipelined masters
// share one master port. A grant lasts for a whole CYC frame. ACK, stall and read
// data are routed back to the current owner only. A watchdog releases an owner
// that has stopped making progress.
module wbx_arbiter2 #(
  parameter int unsigned ADR_W   = 16,
  parameter int unsigned DAT_W   = 32,
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned OUT_W   = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n_i,
  // master 0
  input  logic               m0_cyc_i,
  input  logic               m0_stb_i,
  input  logic               m0_we_i,
  input  logic [ADR_W-1:0]   m0_adr_i,
  input  logic [DAT_W/8-1:0] m0_sel_i,
  input  logic [DAT_W-1:0]   m0_dat_i,
  output logic [DAT_W-1:0]   m0_dat_o,
  output logic               m0_stall_o,
  output logic               m0_ack_o,
  // master 1
  input  logic               m1_cyc_i,
  input  logic               m1_stb_i,
  input  logic               m1_we_i,
  input  logic [ADR_W-1:0]   m1_adr_i,
  input  logic [DAT_W/8-1:0] m1_sel_i,
  input  logic [DAT_W-1:0]   m1_dat_i,
  output logic [DAT_W-1:0]   m1_dat_o,
  output logic               m1_stall_o,
  output logic               m1_ack_o,
  // shared port towards the interconnect
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  input  logic               wbm_stall_i,
  input  logic               wbm_ack_i,
  // forced-release indication
  output logic               timeout_o
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              timeout_q, timeout_d;

  // owner-relative view of the bus
  logic own_cyc;
  logic own_stb;
  logic other_cyc;
  logic accept;
  logic ack;
  logic wd_active;
  logic wd_expire;

  // Reduce the two request sets to "owner" and "other" for the current grant.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    other_cyc = 1'b0;
    case (state_q)
      GNT0: begin
        own_cyc   = m0_cyc_i;
        own_stb   = m0_stb_i;
        other_cyc = m1_cyc_i;
      end
      GNT1: begin
        own_cyc   = m1_cyc_i;
        own_stb   = m1_stb_i;
        other_cyc = m0_cyc_i;
      end
      default: begin
        own_cyc   = 1'b0;
        own_stb   = 1'b0;
        other_cyc = 1'b0;
      end
    endcase
    accept    = own_cyc & own_stb & ~wbm_stall_i;
    ack       = own_cyc & wbm_ack_i;
    // the watchdog runs only while something is pending and nothing moved this cycle
    wd_active = own_cyc & ((out_q != '0) | own_stb);
    wd_expire = wd_active & ~accept & ~ack & (wdog_q == WD_LAST);
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: frame-level grant, direct handoff on release or watchdog expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          state_d = GNT0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i || wd_expire) begin
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i || wd_expire) begin
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the round-robin pointer, outstanding counter and watchdog.
  always_comb begin
    last_d    = last_q;
    out_d     = out_q;
    wdog_d    = wdog_q;
    timeout_d = 1'b0;

    if (state_d == GNT0 && state_q != GNT0) begin
      last_d = 1'b0;
    end else if (state_d == GNT1 && state_q != GNT1) begin
      last_d = 1'b1;
    end

    if (!own_cyc) begin
      // idle or normal release: nothing can be pending for the next owner
      out_d  = '0;
      wdog_d = '0;
    end else if (wd_expire) begin
      timeout_d = 1'b1;
      out_d     = '0;
      wdog_d    = '0;
    end else begin
      if (accept && !ack && out_q != '1) begin
        out_d = out_q + OUT_W'(1);
      end else if (ack && !accept && out_q != '0) begin
        out_d = out_q - OUT_W'(1);
      end

      if (accept || ack) begin
        wdog_d = '0;
      end else if (wd_active) begin
        wdog_d = wdog_q + WD_W'(1);
      end else begin
        wdog_d = '0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      last_q    <= 1'b1;
      out_q     <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      out_q     <= out_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Output mux: the owner drives the shared port and sees the slave responses.
  always_comb begin
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_adr_o  = '0;
    wbm_sel_o  = '0;
    wbm_dat_o  = '0;
    m0_dat_o   = '0;
    m0_stall_o = 1'b1;
    m0_ack_o   = 1'b0;
    m1_dat_o   = '0;
    m1_stall_o = 1'b1;
    m1_ack_o   = 1'b0;
    case (state_q)
      GNT0: begin
        wbm_cyc_o  = m0_cyc_i;
        wbm_stb_o  = m0_stb_i;
        wbm_we_o   = m0_we_i;
        wbm_adr_o  = m0_adr_i;
        wbm_sel_o  = m0_sel_i;
        wbm_dat_o  = m0_dat_i;
        m0_dat_o   = wbm_dat_i;
        m0_stall_o = wbm_stall_i;
        m0_ack_o   = wbm_ack_i;
      end
      GNT1: begin
        wbm_cyc_o  = m1_cyc_i;
        wbm_stb_o  = m1_stb_i;
        wbm_we_o   = m1_we_i;
        wbm_adr_o  = m1_adr_i;
        wbm_sel_o  = m1_sel_i;
        wbm_dat_o  = m1_dat_i;
        m1_dat_o   = wbm_dat_i;
        m1_stall_o = wbm_stall_i;
        m1_ack_o   = wbm_ack_i;
      end
      default: begin
        wbm_cyc_o = 1'b0;
      end
    endcase
    timeout_o = timeout_q;
  end

endmodule

// File: tb/tb_wbx_arbiter2.sv
// Bench for wbx_arbiter2: directed scenarios followed by a random phase, all checked
// cycle by cycle against a frame-level behavioural model of the arbiter.
module tb_wbx_arbiter2;

  localparam int ADR_W   = 16;
  localparam int DAT_W   = 32;
  localparam int SEL_W   = DAT_W / 8;
  localparam int TIMEOUT = 16;
  localparam int OUT_W   = 4;
  localparam int OUT_MAX = (1 << OUT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  logic             m0_cyc, m0_stb, m0_we;
  logic [ADR_W-1:0] m0_adr;
  logic [SEL_W-1:0] m0_sel;
  logic [DAT_W-1:0] m0_dat;
  logic [DAT_W-1:0] m0_dat_o;
  logic             m0_stall_o, m0_ack_o;

  logic             m1_cyc, m1_stb, m1_we;
  logic [ADR_W-1:0] m1_adr;
  logic [SEL_W-1:0] m1_sel;
  logic [DAT_W-1:0] m1_dat;
  logic [DAT_W-1:0] m1_dat_o;
  logic             m1_stall_o, m1_ack_o;

  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [SEL_W-1:0] wbm_sel_o;
  logic [DAT_W-1:0] wbm_dat_o;
  logic [DAT_W-1:0] s_rdat;
  logic             s_stall, s_ack;
  logic             timeout_o;

  always #5 clk = ~clk;

  wbx_arbiter2 #(
    .ADR_W  (ADR_W),
    .DAT_W  (DAT_W),
    .TIMEOUT(TIMEOUT),
    .OUT_W  (OUT_W)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m0_cyc_i   (m0_cyc),
    .m0_stb_i   (m0_stb),
    .m0_we_i    (m0_we),
    .m0_adr_i   (m0_adr),
    .m0_sel_i   (m0_sel),
    .m0_dat_i   (m0_dat),
    .m0_dat_o   (m0_dat_o),
    .m0_stall_o (m0_stall_o),
    .m0_ack_o   (m0_ack_o),
    .m1_cyc_i   (m1_cyc),
    .m1_stb_i   (m1_stb),
    .m1_we_i    (m1_we),
    .m1_adr_i   (m1_adr),
    .m1_sel_i   (m1_sel),
    .m1_dat_i   (m1_dat),
    .m1_dat_o   (m1_dat_o),
    .m1_stall_o (m1_stall_o),
    .m1_ack_o   (m1_ack_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (s_rdat),
    .wbm_stall_i(s_stall),
    .wbm_ack_i  (s_ack),
    .timeout_o  (timeout_o)
  );

  int checks = 0;
  int errors = 0;

  // behavioural model: owner -1 = nobody, 0 = m0, 1 = m1
  int mo_owner;
  int mo_last;
  int mo_outs;
  int mo_wd;
  bit mo_to;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mo_owner = -1;
    mo_last  = 1;
    mo_outs  = 0;
    mo_wd    = 0;
    mo_to    = 1'b0;
  endtask

  // Advance the model over one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit ca[2];
    bit s_own, acc, ak;
    int o;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ca[0] = m0_cyc;
    ca[1] = m1_cyc;
    mo_to = 1'b0;
    if (mo_owner < 0) begin
      mo_outs = 0;
      mo_wd   = 0;
      if (ca[0] && ca[1]) mo_owner = 1 - mo_last;
      else if (ca[0])     mo_owner = 0;
      else if (ca[1])     mo_owner = 1;
      if (mo_owner >= 0) mo_last = mo_owner;
    end else begin
      o     = mo_owner;
      s_own = (o == 0) ? m0_stb : m1_stb;
      if (!ca[o]) begin
        mo_outs  = 0;
        mo_wd    = 0;
        mo_owner = ca[1-o] ? 1 - o : -1;
        if (mo_owner >= 0) mo_last = mo_owner;
      end else begin
        acc = s_own && !s_stall;
        ak  = s_ack;
        if (!acc && !ak && (mo_outs > 0 || s_own) && mo_wd == TIMEOUT - 1) begin
          mo_to    = 1'b1;
          mo_outs  = 0;
          mo_wd    = 0;
          mo_owner = ca[1-o] ? 1 - o : -1;
          if (mo_owner >= 0) mo_last = mo_owner;
        end else begin
          if (acc || ak)                  mo_wd = 0;
          else if (mo_outs > 0 || s_own)  mo_wd = mo_wd + 1;
          else                            mo_wd = 0;
          mo_outs = mo_outs + int'(acc) - int'(ak);
          if (mo_outs < 0)       mo_outs = 0;
          if (mo_outs > OUT_MAX) mo_outs = OUT_MAX;
        end
      end
    end
  endtask

  // Compare every output with what the model says the current owner implies.
  task automatic check_all();
    logic             ecyc, estb, ewe;
    logic [ADR_W-1:0] eadr;
    logic [SEL_W-1:0] esel;
    logic [DAT_W-1:0] edat, e0dat, e1dat;
    logic             e0stall, e1stall, e0ack, e1ack;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0; eadr = '0; esel = '0; edat = '0;
    e0dat = '0; e1dat = '0; e0stall = 1'b1; e1stall = 1'b1; e0ack = 1'b0; e1ack = 1'b0;
    if (mo_owner == 0) begin
      ecyc = m0_cyc; estb = m0_stb; ewe = m0_we; eadr = m0_adr; esel = m0_sel; edat = m0_dat;
      e0dat = s_rdat; e0stall = s_stall; e0ack = s_ack;
    end else if (mo_owner == 1) begin
      ecyc = m1_cyc; estb = m1_stb; ewe = m1_we; eadr = m1_adr; esel = m1_sel; edat = m1_dat;
      e1dat = s_rdat; e1stall = s_stall; e1ack = s_ack;
    end
    chk1("wbm_cyc", wbm_cyc_o, ecyc);
    chk1("wbm_stb", wbm_stb_o, estb);
    chk1("wbm_we", wbm_we_o, ewe);
    chkv("wbm_adr", 64'(wbm_adr_o), 64'(eadr));
    chkv("wbm_sel", 64'(wbm_sel_o), 64'(esel));
    chkv("wbm_dat", 64'(wbm_dat_o), 64'(edat));
    chkv("m0_dat", 64'(m0_dat_o), 64'(e0dat));
    chkv("m1_dat", 64'(m1_dat_o), 64'(e1dat));
    chk1("m0_stall", m0_stall_o, e0stall);
    chk1("m1_stall", m1_stall_o, e1stall);
    chk1("m0_ack", m0_ack_o, e0ack);
    chk1("m1_ack", m1_ack_o, e1ack);
    chk1("timeout", timeout_o, mo_to);
    chkv("outstanding", 64'(dut.out_q), 64'(mo_outs));
  endtask

  // Check the settled cycle, predict the edge, then move to just after it.
  task automatic clk_step();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  int unsigned exp_out[6] = '{1, 2, 2, 2, 1, 0};
  int acks;
  bit quiet;

  initial begin
    rst_n  = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_sel = '0; m0_dat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 16'h0200; m1_sel = 4'h3;
    m1_dat = 32'hCAFE0001;
    s_stall = 1'b0; s_ack = 1'b0; s_rdat = 32'h5555AAAA;
    model_reset();

    // reset values
    #1;
    chk1("rst_wbm_cyc", wbm_cyc_o, 1'b0);
    chk1("rst_m0_stall", m0_stall_o, 1'b1);
    chk1("rst_m1_stall", m1_stall_o, 1'b1);
    chkv("rst_m0_dat", 64'(m0_dat_o), 64'(0));
    chk1("rst_timeout", timeout_o, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clk_step();

    // single m0 write after reset
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
    m0_adr = 16'h0004; m0_dat = 32'hDEADBEEF; m0_sel = 4'hF;
    #1;
    chk1("t1_stall_first", m0_stall_o, 1'b1);
    chk1("t1_cyc_first", wbm_cyc_o, 1'b0);
    clk_step();
    chk1("t1_cyc", wbm_cyc_o, 1'b1);
    chkv("t1_adr", 64'(wbm_adr_o), 64'h0004);
    chkv("t1_dat", 64'(wbm_dat_o), 64'hDEADBEEF);
    chkv("t1_sel", 64'(wbm_sel_o), 64'hF);
    chk1("t1_we", wbm_we_o, 1'b1);
    chk1("t1_stall_granted", m0_stall_o, 1'b0);
    clk_step();
    m0_stb = 1'b0; s_ack = 1'b1;
    #1;
    chk1("t1_m0_ack", m0_ack_o, 1'b1);
    chk1("t1_m1_ack", m1_ack_o, 1'b0);
    clk_step();
    s_ack = 1'b0; m0_cyc = 1'b0;
    clk_step();
    chk1("t1_released", wbm_cyc_o, 1'b0);

    // reset in the middle of an m0 burst
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 16'h0100;
    clk_step();
    clk_step();
    clk_step();
    #1;
    rst_n = 1'b0;
    #1;
    chk1("rst_mid_cyc", wbm_cyc_o, 1'b0);
    chk1("rst_mid_m0_stall", m0_stall_o, 1'b1);
    chk1("rst_mid_m1_stall", m1_stall_o, 1'b1);
    chk1("rst_mid_timeout", timeout_o, 1'b0);
    model_reset();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    clk_step();
    clk_step();
    rst_n = 1'b1;
    clk_step();

    // simultaneous requests after reset: m0 first, then direct handoff to m1
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    #1;
    chk1("t2_m0_wait", m0_stall_o, 1'b1);
    chk1("t2_m1_wait", m1_stall_o, 1'b1);
    clk_step();
    chkv("t2_first_owner", 64'(wbm_adr_o), 64'h0100);
    chk1("t2_m1_stalled", m1_stall_o, 1'b1);
    m0_cyc = 1'b0;
    clk_step();
    chk1("t2_handoff_cyc", wbm_cyc_o, 1'b1);
    chkv("t2_handoff_owner", 64'(wbm_adr_o), 64'h0200);
    chk1("t2_m1_stall", m1_stall_o, 1'b0);
    m1_cyc = 1'b0;
    clk_step();
    clk_step();

    // both keep requesting: grants alternate m0, m1, m0, m1
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    clk_step();
    for (int k = 0; k < 4; k++) begin
      chkv("t3_alt_owner", 64'(wbm_adr_o), (k % 2 == 0) ? 64'h0100 : 64'h0200);
      if (k % 2 == 0) m0_stb = 1'b1; else m1_stb = 1'b1;
      clk_step();
      m0_stb = 1'b0; m1_stb = 1'b0; s_ack = 1'b1;
      #1;
      chk1("t3_alt_ack", (k % 2 == 0) ? m0_ack_o : m1_ack_o, 1'b1);
      clk_step();
      s_ack = 1'b0;
      if (k % 2 == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
      clk_step();
      m0_cyc = 1'b1; m1_cyc = 1'b1;
    end
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    clk_step();
    clk_step();

    // m0 burst of four reads, each acked two cycles after its accept
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
    clk_step();
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      m0_stb = (i < 4);
      m0_adr = 16'(i * 4);
      s_ack  = (i >= 2);
      s_rdat = (i >= 2) ? 32'(8'h11 * (i - 1)) : 32'h0;
      #1;
      if (i >= 2) begin
        chk1("t4_ack", m0_ack_o, 1'b1);
        chkv("t4_rdata", 64'(m0_dat_o), 64'(8'h11 * (i - 1)));
        if (m0_ack_o) acks++;
      end
      clk_step();
      chkv("t4_outstanding", 64'(dut.out_q), 64'(exp_out[i]));
    end
    s_ack = 1'b0;
    chkv("t4_ack_count", 64'(acks), 64'(4));
    m0_cyc = 1'b0;
    clk_step();
    clk_step();

    // slave never acks m0: watchdog releases to m1
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0100;
    clk_step();
    m1_cyc = 1'b1;
    clk_step();
    m0_stb = 1'b0;
    for (int n = 1; n < TIMEOUT; n++) begin
      clk_step();
      chk1("t5_no_timeout_yet", timeout_o, 1'b0);
    end
    clk_step();
    chk1("t5_timeout_pulse", timeout_o, 1'b1);
    chkv("t5_m1_owner", 64'(wbm_adr_o), 64'h0200);
    chk1("t5_m0_stalled", m0_stall_o, 1'b1);
    s_ack = 1'b1;
    #1;
    chk1("t5_late_ack_m1", m1_ack_o, 1'b1);
    chk1("t5_late_ack_m0", m0_ack_o, 1'b0);
    clk_step();
    s_ack = 1'b0;
    chk1("t5_pulse_end", timeout_o, 1'b0);
    m1_cyc = 1'b1;
    m0_cyc = 1'b0;
    clk_step();
    m1_cyc = 1'b0;
    clk_step();
    clk_step();

    // random traffic with periodic stretches where the slave stalls and never acks
    for (int n = 0; n < 1500; n++) begin
      quiet = (n % 300) >= 250;
      if (m0_cyc) begin
        if ($urandom_range(7) == 0) m0_cyc = 1'b0;
      end else if ($urandom_range(2) == 0) m0_cyc = 1'b1;
      if (m1_cyc) begin
        if ($urandom_range(7) == 0) m1_cyc = 1'b0;
      end else if ($urandom_range(2) == 0) m1_cyc = 1'b1;
      m0_stb = m0_cyc && ($urandom_range(1) == 1);
      m1_stb = m1_cyc && ($urandom_range(1) == 1);
      m0_we  = ($urandom_range(1) == 1);
      m1_we  = ($urandom_range(1) == 1);
      m0_adr = ADR_W'($urandom);
      m1_adr = ADR_W'($urandom);
      m0_sel = SEL_W'($urandom);
      m1_sel = SEL_W'($urandom);
      m0_dat = DAT_W'($urandom);
      m1_dat = DAT_W'($urandom);
      s_stall = quiet || ($urandom_range(3) == 0);
      s_ack   = !quiet && ($urandom_range(2) == 0);
      s_rdat  = DAT_W'($urandom);
      clk_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
